// File: rtl/pgood_pkg.sv
// Shared encodings for the card-side power-good monitor.
package pgood_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_WAIT_GOOD = 2'b01,
    ST_ON        = 2'b10,
    ST_FAULT     = 2'b11
  } pwr_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_TIMEOUT = 2'b01,
    FC_DROP    = 2'b10
  } fault_code_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pgood_debounce.sv
// Two-flop synchroniser for the asynchronous pgood, followed by a level debouncer
// that accepts a new level only after it has held for DEBOUNCE_CYCLES cycles.
module pgood_debounce
  import pgood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pgood_raw,
  output logic pgood
);

  localparam int unsigned   DW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (s2_q != level_q) begin
      if (dcnt_q == DLAST) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      s1_q    <= pgood_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign pgood = level_q;

endmodule

// File: rtl/pgood_monitor.sv
// Power sequencing monitor: qualifies card pgood against penable, enforces a turn-on
// timeout, latches dropout/timeout faults and gates the peltier enables on power-good.
module pgood_monitor
  import pgood_pkg::*;
#(
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned PGOOD_TIMEOUT   = 400000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       delay_clk,
  input  logic       reset,
  input  logic       penable,
  input  logic       pgood_raw,
  input  logic       peltEnable1_in,
  input  logic       peltEnable2_in,
  input  logic       fault_clear,
  output logic       pgood_q,
  output logic       peltEnable1_out,
  output logic       peltEnable2_out,
  output logic       pwr_fault,
  output logic [1:0] fault_code,
  output logic [1:0] pwr_state
);

  localparam logic [CNT_W-1:0] TLAST = CNT_W'(PGOOD_TIMEOUT - 1);

  pwr_state_e       state_q, state_d;
  fault_code_e      fault_code_q, fault_code_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             pwr_fault_q, pwr_fault_d;
  logic             pelt1_q, pelt1_d;
  logic             pelt2_q, pelt2_d;
  logic             pgood_ok;

  pgood_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (delay_clk),
    .reset    (reset),
    .pgood_raw(pgood_raw),
    .pgood    (pgood_ok)
  );

  always_ff @(posedge delay_clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      fault_code_q <= FC_NONE;
      tcnt_q       <= '0;
      pwr_fault_q  <= 1'b0;
      pelt1_q      <= 1'b0;
      pelt2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      tcnt_q       <= tcnt_d;
      pwr_fault_q  <= pwr_fault_d;
      pelt1_q      <= pelt1_d;
      pelt2_q      <= pelt2_d;
    end
  end

  // In WAIT_GOOD a qualified pgood outranks the timeout; in ON penable outranks dropout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (penable) state_d = ST_WAIT_GOOD;
      end
      ST_WAIT_GOOD: begin
        if (!penable)             state_d = ST_OFF;
        else if (pgood_ok)        state_d = ST_ON;
        else if (tcnt_q == TLAST) state_d = ST_FAULT;
      end
      ST_ON: begin
        if (!penable)       state_d = ST_OFF;
        else if (!pgood_ok) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clear && !penable) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Registered outputs are computed from the next state so they move on the same edge.
  always_comb begin
    tcnt_d       = (state_q == ST_WAIT_GOOD) ? tcnt_q + CNT_W'(1) : '0;
    fault_code_d = fault_code_q;
    if (state_q == ST_WAIT_GOOD && state_d == ST_FAULT) fault_code_d = FC_TIMEOUT;
    if (state_q == ST_ON && state_d == ST_FAULT)        fault_code_d = FC_DROP;
    if (state_q == ST_FAULT && state_d == ST_OFF)       fault_code_d = FC_NONE;
    pwr_fault_d = (state_d == ST_FAULT);
    pelt1_d     = peltEnable1_in & (state_d == ST_ON);
    pelt2_d     = peltEnable2_in & (state_d == ST_ON);
  end

  assign pgood_q         = pgood_ok;
  assign peltEnable1_out = pelt1_q;
  assign peltEnable2_out = pelt2_q;
  assign pwr_fault       = pwr_fault_q;
  assign fault_code      = fault_code_q;
  assign pwr_state       = state_q;

endmodule

// File: tb/tb_pgood_monitor.sv
// Directed bench for pgood_monitor with DEBOUNCE_CYCLES=4 and PGOOD_TIMEOUT=100.
module tb_pgood_monitor;

  logic       delay_clk = 1'b0;
  logic       reset, penable, pgood_raw;
  logic       peltEnable1_in, peltEnable2_in, fault_clear;
  logic       pgood_q, peltEnable1_out, peltEnable2_out, pwr_fault;
  logic [1:0] fault_code, pwr_state;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 delay_clk = ~delay_clk;

  pgood_monitor #(
    .CNT_W          (19),
    .PGOOD_TIMEOUT  (100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .delay_clk      (delay_clk),
    .reset          (reset),
    .penable        (penable),
    .pgood_raw      (pgood_raw),
    .peltEnable1_in (peltEnable1_in),
    .peltEnable2_in (peltEnable2_in),
    .fault_clear    (fault_clear),
    .pgood_q        (pgood_q),
    .peltEnable1_out(peltEnable1_out),
    .peltEnable2_out(peltEnable2_out),
    .pwr_fault      (pwr_fault),
    .fault_code     (fault_code),
    .pwr_state      (pwr_state)
  );

  // Expected outputs packed as {pgood_q, pelt1, pelt2, pwr_fault, fault_code, pwr_state}.
  typedef struct {
    logic        rst;
    logic        pen;
    logic        raw;
    logic        p1;
    logic        p2;
    logic        fclr;
    int unsigned cyc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge delay_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {pgood_q, peltEnable1_out, peltEnable2_out, pwr_fault, fault_code, pwr_state};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b_%b%b_%b_%b_%b expected %b_%b%b_%b_%b_%b", name,
               act[7], act[6], act[5], act[4], act[3:2], act[1:0],
               exp[7], exp[6], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic rst, input logic pen, input logic raw,
                       input logic p1, input logic p2, input logic fclr);
    reset          = rst;
    penable        = pen;
    pgood_raw      = raw;
    peltEnable1_in = p1;
    peltEnable2_in = p2;
    fault_clear    = fclr;
  endtask

  initial begin
    //                rst   pen   raw   p1    p2    fclr  cyc  pg_12_f_cc_ss
    // reset with penable/pgood high, then first turn-on
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3,  8'b0_00_0_00_00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4,  8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_11_0_00_10});
    // independent peltier gating while ON
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,  8'b1_10_0_00_10});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1,  8'b1_01_0_00_10});
    // normal power-down, then pgood settles low
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_00_0_00_00});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8,  8'b0_00_0_00_00});
    // normal turn-on: pgood rises 20 cycles after penable
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20, 8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5,  8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_11_0_00_10});
    // 3-cycle low glitch rejected
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3,  8'b1_11_0_00_10});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6,  8'b1_11_0_00_10});
    // dropout: pgood_q falls at edge 6, FAULT and peltier drop at edge 7
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5,  8'b1_11_0_00_10});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1,  8'b0_11_0_00_10});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1,  8'b0_00_1_10_11});
    // fault_clear ignored while penable high, honoured once low
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,  8'b0_00_1_10_11});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3,  8'b0_00_1_10_11});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1,  8'b0_00_0_00_00});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2,  8'b0_00_0_00_00});
    // penable and pgood_q fall together in ON: clean OFF
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7,  8'b1_11_0_00_10});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6,  8'b0_11_0_00_10});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1,  8'b0_00_0_00_00});
    // pgood_q qualifies on the timeout cycle: ON wins
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 94, 8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5,  8'b0_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_00_0_00_01});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,  8'b1_11_0_00_10});
    // dropout to FAULT, then reset aborts it
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7,  8'b0_00_1_10_11});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1,  8'b0_00_0_00_00});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2,  8'b0_00_0_00_00});

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pen, vecs[i].raw, vecs[i].p1, vecs[i].p2, vecs[i].fclr);
      tick(vecs[i].cyc);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Turn-on timeout: exactly 100 cycles in WAIT_GOOD, then FAULT with code 01.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int unsigned c = 0; c < 100; c++) begin
      tick(1);
      check($sformatf("wait_cyc%0d", c), 8'b0_00_0_00_01);
    end
    tick(1);
    check("timeout_fault", 8'b0_00_1_01_11);
    tick(3);
    check("timeout_hold", 8'b0_00_1_01_11);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    check("timeout_clear", 8'b0_00_0_00_00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check("after_clear", 8'b0_00_0_00_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
